axi4_rd_outstanding_limit: RTL and testbench
============================================

// Module: axi4_rd_outstanding_limit
// PURPOSE
//  - AR-channel gate in front of a read slave: counts outstanding read bursts and stalls AR once MAX_OUTSTANDING are in flight.
//  - Observes R (not in the data path) and checks in-order RID on every RLAST against an internal ARID queue.
//  - Optional watchdog on the response side. Output is well-formed traffic for the downstream read-burst tracker/slave.
// PARAMETERS
//  IDSIZE           4     AXI ID width
//  ASIZE            32    address width
//  LSIZE            8     ARLEN width
//  MAX_OUTSTANDING  16    max in-flight bursts, 1..255; also ID queue depth
//  MAX_CYCLE        1000  response-silence limit in cycles (watchdog only)
// PORTS
//  axi_aclk      in   1          clock
//  axi_aresetn   in   1          async reset, active low
//  s_arid        in   IDSIZE     upstream AR id
//  s_araddr      in   ASIZE      upstream AR address
//  s_arlen       in   LSIZE      upstream AR length
//  s_arvalid     in   1          upstream AR valid
//  s_arready     out  1          upstream AR ready
//  m_arid        out  IDSIZE     downstream AR id (= s_arid)
//  m_araddr      out  ASIZE      downstream AR address (= s_araddr)
//  m_arlen       out  LSIZE      downstream AR length (= s_arlen)
//  m_arvalid     out  1          downstream AR valid
//  m_arready     in   1          downstream AR ready
//  axi_rid       in   IDSIZE     observed R id
//  axi_rvalid    in   1          observed R valid
//  axi_rready    in   1          observed R ready
//  axi_rlast     in   1          observed R last
//  outstanding   out  8          in-flight burst count
//  id_error      out  1          sticky: RID mismatch at RLAST
//  underflow     out  1          sticky: RLAST with nothing outstanding
//  timeout_error out  1          sticky: watchdog fired
// BEHAVIOUR
//  - ar_hs = m_arvalid & m_arready; r_end = axi_rvalid & axi_rready & axi_rlast.
//  - block = (outstanding == MAX_OUTSTANDING), from registered count only.
//  - m_arvalid = s_arvalid & ~block; s_arready = m_arready & ~block; payload passes through, zero latency.
//  - outstanding: +1 on ar_hs only, -1 on r_end only (when >0), unchanged on both; visible next cycle.
//  - ID queue: push s_arid on ar_hs; pop on r_end when not empty. Cannot overflow because AR is blocked at full.
//  - On r_end with queue non-empty: axi_rid != head -> id_error <= 1 next cycle, sticky.
//  - r_end with outstanding==0: underflow <= 1, count stays 0, no pop. A same-cycle ar_hs still pushes and count -> 1.
//  - Async reset: outstanding=0, queue empty, all error flags 0. Reset mid-burst drops all in-flight state; no error raised.
//  - Error flags clear only on reset and do not gate traffic.
// CONFIGURATION
//  - AXI4_RD_OUTSTANDING_TIMEOUT_EN defined: 16-bit tcnt.
//    Cleared when outstanding==0 or on any R handshake; else +1, saturating.
//    tcnt >= MAX_CYCLE -> timeout_error <= 1, sticky.
//  - Undefined: no counter; timeout_error tied 0.
// STRUCTURE
//  - Shared package axi4_track_pkg: count width constant (8), error-flag struct typedef {id_error, underflow, timeout}.
//  - Sub-module axi4_id_fifo: sync FIFO, DEPTH=MAX_OUTSTANDING, DSIZE=IDSIZE, first-word-fall-through, push/pop/head/empty/full.
//  - Top: gate logic, counter, compare, watchdog.
// TESTING
//  - Reset: all outputs 0, s_arready follows m_arready.
//  - 16 back-to-back ARs, no R: outstanding=16, m_arvalid=0, s_arready=0 on 17th; one r_end -> AR accepted next cycle.
//  - ar_hs and r_end same cycle at count 5: count stays 5; queue order preserved.
//  - ARIDs 1,2,3 issued; RLAST ids 1,3: id_error=1 one cycle after the second RLAST.
//  - r_end at count 0: underflow=1, outstanding=0; simultaneous AR gives count 1.
//  - With _EN, MAX_CYCLE=50: one AR, silence -> timeout_error=1 at cycle 50. Without _EN: stays 0.

Source files
------------

// File: rtl/axi4_track_pkg.sv
// rtl/axi4_track_pkg.sv - shared constants and error-flag type for the AXI4 read tracker
package axi4_track_pkg;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic id_error;
    logic underflow;
    logic timeout;
  } err_flags_t;

endpackage

// File: rtl/axi4_id_fifo.sv
// rtl/axi4_id_fifo.sv - synchronous first-word-fall-through FIFO holding in-flight ARIDs
module axi4_id_fifo #(
  parameter int DEPTH = 16,
  parameter int DSIZE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] data,
  input  logic             pop,
  output logic [DSIZE-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];

  // Storage carries no reset: validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/axi4_rd_outstanding_limit.sv
// rtl/axi4_rd_outstanding_limit.sv - AR gate limiting outstanding read bursts, in-order RID checker
// Optional response watchdog enabled by defining AXI4_RD_OUTSTANDING_TIMEOUT_EN.
module axi4_rd_outstanding_limit
  import axi4_track_pkg::*;
#(
  parameter int IDSIZE          = 4,
  parameter int ASIZE           = 32,
  parameter int LSIZE           = 8,
  parameter int MAX_OUTSTANDING = 16,
  parameter int MAX_CYCLE       = 1000
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic [IDSIZE-1:0] s_arid,
  input  logic [ASIZE-1:0]  s_araddr,
  input  logic [LSIZE-1:0]  s_arlen,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [IDSIZE-1:0] m_arid,
  output logic [ASIZE-1:0]  m_araddr,
  output logic [LSIZE-1:0]  m_arlen,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [IDSIZE-1:0] axi_rid,
  input  logic              axi_rvalid,
  input  logic              axi_rready,
  input  logic              axi_rlast,
  output logic [CNT_W-1:0]  outstanding,
  output logic              id_error,
  output logic              underflow,
  output logic              timeout_error
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]  cnt_q;
  err_flags_t        err_q, err_d;
  logic              block, ar_hs, r_end, cnt_zero, inc, dec;
  logic              q_empty, q_full, tmo_hit;
  logic [IDSIZE-1:0] q_head;

  // Blocking looks only at the registered count, so a completing burst frees a slot one cycle later.
  assign block     = (cnt_q == MAX_CNT);
  assign m_arvalid = s_arvalid & ~block;
  assign s_arready = m_arready & ~block;
  assign m_arid    = s_arid;
  assign m_araddr  = s_araddr;
  assign m_arlen   = s_arlen;

  assign ar_hs    = m_arvalid & m_arready;
  assign r_end    = axi_rvalid & axi_rready & axi_rlast;
  assign cnt_zero = (cnt_q == '0);
  assign inc      = ar_hs;
  assign dec      = r_end & ~cnt_zero;

  axi4_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .DSIZE (IDSIZE)
  ) u_id_fifo (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .push  (ar_hs & ~q_full),
    .data  (s_arid),
    .pop   (r_end & ~q_empty),
    .head  (q_head),
    .empty (q_empty),
    .full  (q_full)
  );

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

`ifdef AXI4_RD_OUTSTANDING_TIMEOUT_EN
  localparam logic [15:0] TLIM = 16'(MAX_CYCLE);

  logic [15:0] tcnt;
  logic        r_hs;

  assign r_hs = axi_rvalid & axi_rready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      tcnt <= '0;
    end else if (cnt_zero || r_hs) begin
      tcnt <= '0;
    end else if (tcnt != 16'hFFFF) begin
      tcnt <= tcnt + 16'd1;
    end
  end

  assign tmo_hit = (tcnt >= TLIM);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    err_d = err_q;
    if (r_end && !q_empty && (axi_rid != q_head)) err_d.id_error = 1'b1;
    if (r_end && cnt_zero)                        err_d.underflow = 1'b1;
    if (tmo_hit)                                  err_d.timeout = 1'b1;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) err_q <= '0;
    else              err_q <= err_d;
  end

  assign outstanding   = cnt_q;
  assign id_error      = err_q.id_error;
  assign underflow     = err_q.underflow;
  assign timeout_error = err_q.timeout;

endmodule

// File: tb/tb_axi4_rd_outstanding_limit.sv
// tb/tb_axi4_rd_outstanding_limit.sv - randomized self-checking bench against a queue-based reference model
module tb_axi4_rd_outstanding_limit;

  localparam int IDSIZE = 4;
  localparam int ASIZE  = 32;
  localparam int LSIZE  = 8;
  localparam int MAXO   = 16;
  localparam int MAXC   = 50;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [IDSIZE-1:0] s_arid = '0;
  logic [ASIZE-1:0]  s_araddr = '0;
  logic [LSIZE-1:0]  s_arlen = '0;
  logic              s_arvalid = 1'b0;
  logic              s_arready;
  logic [IDSIZE-1:0] m_arid;
  logic [ASIZE-1:0]  m_araddr;
  logic [LSIZE-1:0]  m_arlen;
  logic              m_arvalid;
  logic              m_arready = 1'b0;
  logic [IDSIZE-1:0] axi_rid = '0;
  logic              axi_rvalid = 1'b0;
  logic              axi_rready = 1'b0;
  logic              axi_rlast = 1'b0;
  logic [7:0]        outstanding;
  logic              id_error, underflow, timeout_error;

  axi4_rd_outstanding_limit #(
    .IDSIZE(IDSIZE), .ASIZE(ASIZE), .LSIZE(LSIZE),
    .MAX_OUTSTANDING(MAXO), .MAX_CYCLE(MAXC)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .axi_rid(axi_rid), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rlast(axi_rlast),
    .outstanding(outstanding), .id_error(id_error), .underflow(underflow),
    .timeout_error(timeout_error)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: in-flight IDs in issue order, sticky flags, response-silence length.
  int unsigned mq[$];
  int          m_idle = 0;
  bit          m_iderr = 0, m_unf = 0, m_tmo = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [IDSIZE-1:0] head_id();
    if (mq.size() == 0) return IDSIZE'($urandom);
    return IDSIZE'(mq[0]);
  endfunction

  task automatic check_state();
    check("outstanding", outstanding, mq.size());
    check("id_error", id_error, m_iderr);
    check("underflow", underflow, m_unf);
    check("timeout_error", timeout_error, m_tmo);
  endtask

  // One clock: drive at posedge+1, check combinational gating, update model, check registered state.
  task automatic cycle(input bit arv, input bit mar, input bit rv, input bit rr, input bit rl,
                       input logic [IDSIZE-1:0] arid, input logic [IDSIZE-1:0] rid);
    bit room, ar_hs, r_end;
    s_arvalid  = arv;
    m_arready  = mar;
    s_arid     = arid;
    s_araddr   = $urandom;
    s_arlen    = LSIZE'($urandom);
    axi_rvalid = rv;
    axi_rready = rr;
    axi_rlast  = rl;
    axi_rid    = rid;
    #1;
    room  = (mq.size() < MAXO);
    ar_hs = arv && mar && room;
    r_end = rv && rr && rl;
    check("m_arvalid", m_arvalid, arv && room);
    check("s_arready", s_arready, mar && room);
    check("passthru", {m_arid, m_araddr, m_arlen}, {arid, s_araddr, s_arlen});
`ifdef AXI4_RD_OUTSTANDING_TIMEOUT_EN
    if (m_idle >= MAXC) m_tmo = 1;
    if (mq.size() == 0 || (rv && rr)) m_idle = 0;
    else if (m_idle < 65535) m_idle++;
`endif
    if (r_end) begin
      if (mq.size() == 0) m_unf = 1;
      else begin
        if (rid != IDSIZE'(mq[0])) m_iderr = 1;
        void'(mq.pop_front());
      end
    end
    if (ar_hs) mq.push_back(arid);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset();
    s_arvalid = 0; m_arready = 0; axi_rvalid = 0; axi_rready = 0; axi_rlast = 0;
    rst_n = 0;
    #2;
    mq.delete();
    m_idle = 0; m_iderr = 0; m_unf = 0; m_tmo = 0;
    check_state();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic drain();
    int guard = 0;
    while (mq.size() != 0 && guard < 64) begin
      cycle(0, 0, 1, 1, 1, 0, head_id());
      guard++;
    end
    check("drained", mq.size(), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    m_arready = 1; #1;
    check("rst_s_arready_hi", s_arready, 1);
    m_arready = 0; #1;
    check("rst_s_arready_lo", s_arready, 0);
    check_state();

    // Fill to the limit, then one completion frees a slot on the following cycle.
    for (int i = 0; i < MAXO; i++) cycle(1, 1, 0, 0, 0, IDSIZE'(i + 1), 0);
    check("full_count", outstanding, MAXO);
    cycle(1, 1, 0, 0, 0, 4'hA, 0);
    cycle(1, 1, 1, 1, 1, 4'hA, head_id());
    cycle(1, 1, 0, 0, 0, 4'hB, 0);
    check("refill_count", outstanding, MAXO);
    drain();

    // Simultaneous AR and RLAST at count 5.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, IDSIZE'(i + 3), 0);
    cycle(1, 1, 1, 1, 1, 4'h9, head_id());
    check("same_cycle_count", outstanding, 5);
    drain();

    // Out-of-order RLAST ids.
    for (int i = 1; i <= 3; i++) cycle(1, 1, 0, 0, 0, IDSIZE'(i), 0);
    cycle(0, 0, 1, 1, 1, 0, 4'd1);
    cycle(0, 0, 1, 1, 1, 0, 4'd3);
    check("id_error_set", id_error, 1);
    do_reset();

    // RLAST with nothing outstanding plus a simultaneous AR.
    cycle(1, 1, 1, 1, 1, 4'h7, 4'h7);
    check("underflow_set", underflow, 1);
    check("underflow_count", outstanding, 1);
    drain();
    do_reset();

    // Response silence with one burst in flight.
    cycle(1, 1, 0, 0, 0, 4'h2, 0);
    for (int i = 0; i < MAXC + 10; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      bit rv;
      logic [IDSIZE-1:0] rid;
      if ($urandom_range(0, 399) == 0) do_reset();
      rv  = ($urandom_range(0, 2) != 0);
      rid = ($urandom_range(0, 19) != 0) ? head_id() : IDSIZE'($urandom);
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            rv, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            IDSIZE'($urandom), rid);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
